// File: rtl/data_level_demux.sv
// Registered 1-to-N valid/ready demux: one holding register, 1-cycle latency, 1 beat/clk pass-through.
// Backpressure: in_ready drops only while the held beat's channel is not ready. Optional per-channel
// drain counters on beat_cnt are enabled with `define DATA_DEMUX_STATS_EN.
module data_level_demux #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    rr_en,
  output logic [DATA_W-1:0]       out_data,
  output logic [2**SEL_W-1:0]     out_valid,
  input  logic [2**SEL_W-1:0]     out_ready,
  output logic [SEL_W-1:0]        cur_sel
`ifdef DATA_DEMUX_STATS_EN
  ,
  output logic [16*(2**SEL_W)-1:0] beat_cnt
`endif
);

  localparam int N_OUT = 2**SEL_W;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   hold_data;
  logic [SEL_W-1:0]    hold_sel;
  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    dest;
  logic                full;
  logic                drain;
  logic                accept;

  assign full     = (state == FULL);
  // Only the channel owning the held beat can release it.
  assign drain    = full & out_ready[hold_sel];
  assign in_ready = ~full | drain;
  assign accept   = in_valid & in_ready;
  assign dest     = rr_en ? rr_ptr : in_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (drain && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Everything is gated by accept, so X on in_data/in_sel with in_valid=0 never lands in state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_sel  <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      hold_data <= in_data;
      hold_sel  <= dest;
      if (rr_en) rr_ptr <= rr_ptr + SEL_W'(1);
    end
  end

  always_comb begin
    out_valid = '0;
    if (full) out_valid[hold_sel] = 1'b1;
  end

  assign out_data = hold_data;
  assign cur_sel  = full ? hold_sel : rr_ptr;

`ifdef DATA_DEMUX_STATS_EN
  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (drain && (hold_sel == SEL_W'(k)) && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign beat_cnt[16*k +: 16] = cnt;
  end
`endif

endmodule

// File: tb/tb_data_level_demux.sv
// Scoreboarded bench for data_level_demux: stimulus pushes expected {channel,data}, a negedge monitor pops on every drain.
module tb_data_level_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [0:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic        rr_en;
  logic [7:0]  out_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [0:0]  cur_sel;
`ifdef DATA_DEMUX_STATS_EN
  logic [31:0] beat_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    int         ch;
  } exp_t;
  exp_t exp_q[$];

  data_level_demux #(.DATA_W(8), .SEL_W(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_sel   (cur_sel)
`ifdef DATA_DEMUX_STATS_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // A drain happens on the next posedge whenever the held channel is ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual ch=%0d data=%0h required=none", k, out_data);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("beat_ch", k, e.ch);
            chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
          end
        end
      end
    end
  end

  // Present one beat and hold it until accepted; returns at posedge+1 with in_valid low.
  task automatic send(input logic [7:0] d, input logic s, input logic rr, input int exp_ch, input bit push);
    bit done;
    done     = 1'b0;
    in_data  = d;
    in_sel   = s;
    rr_en    = rr;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) exp_q.push_back('{data: d, ch: exp_ch});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
    end
  endtask

  initial begin
    int c0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    in_sel    = 1'b1;
    rr_en     = 1'b0;
    out_ready = 2'b11;

    // T1: reset with in_valid high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {30'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_cur_sel", {31'd0, cur_sel}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_beat", {30'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // T2: steered by in_sel
    send(8'hA5, 1'b1, 1'b0, 1, 1'b1);
    @(negedge clk);
    chk("t2_valid_a5", {30'd0, out_valid}, 32'h2);
    chk("t2_data_a5", {24'd0, out_data}, 32'hA5);
    chk("t2_cur_sel", {31'd0, cur_sel}, 32'd1);
    @(posedge clk);
    #1;
    send(8'h3C, 1'b0, 1'b0, 0, 1'b1);
    @(negedge clk);
    chk("t2_valid_3c", {30'd0, out_valid}, 32'h1);
    chk("t2_data_3c", {24'd0, out_data}, 32'h3C);
    @(posedge clk);
    #1;

    // T3: backpressure on ch0 while ch1 is ready, then drain and reload on one edge
    out_ready = 2'b10;
    send(8'h11, 1'b0, 1'b0, 0, 1'b1);
    in_data  = 8'h22;
    in_sel   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", {30'd0, out_valid}, 32'h1);
      chk("t3_stall_ready", {31'd0, in_ready}, 32'd0);
      chk("t3_stall_data", {24'd0, out_data}, 32'h11);
      @(posedge clk);
      #1;
    end
    out_ready = 2'b11;
    @(negedge clk);
    chk("t3_release_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back('{data: 8'h22, ch: 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_reload_valid", {30'd0, out_valid}, 32'h2);
    chk("t3_reload_data", {24'd0, out_data}, 32'h22);
    @(posedge clk);
    #1;

    // T4: round-robin stream, one beat per clock across alternating channels
    c0 = cyc;
    send(8'h01, 1'b1, 1'b1, 0, 1'b1);
    send(8'h02, 1'b0, 1'b1, 1, 1'b1);
    send(8'h03, 1'b1, 1'b1, 0, 1'b1);
    send(8'h04, 1'b0, 1'b1, 1, 1'b1);
    chk("t4_cycles", cyc - c0, 32'd4);
    repeat (2) @(posedge clk);
    #1;

    // T5: reset drops a held beat and clears rr_ptr
    send(8'h55, 1'b1, 1'b1, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5_rr_ptr_one", {31'd0, cur_sel}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 2'b00;
    send(8'h77, 1'b1, 1'b0, 1, 1'b0);
    @(negedge clk);
    chk("t5_full_valid", {30'd0, out_valid}, 32'h2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", {30'd0, out_valid}, 32'd0);
    chk("t5_rst_rr_ptr", {31'd0, cur_sel}, 32'd0);
    chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;

    // rr_ptr holds with rr_en=0 and survives toggling rr_en
    send(8'h61, 1'b1, 1'b1, 0, 1'b1);
    send(8'h62, 1'b0, 1'b0, 0, 1'b1);
    send(8'h63, 1'b0, 1'b1, 1, 1'b1);
    repeat (2) @(posedge clk);
    #1;

`ifdef DATA_DEMUX_STATS_EN
    // T6: per-channel drain counters and saturation
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_cnt_reset", beat_cnt, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(8'h80 + 8'(i), 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 5; i++) send(8'h90 + 8'(i), 1'b1, 1'b0, 1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_cnt_3_5", beat_cnt, {16'd5, 16'd3});
    @(posedge clk);
    #1;
    for (int i = 0; i < 70000; i++) send(8'(i), 1'b0, 1'b0, 0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_ch0_sat", {16'd0, beat_cnt[15:0]}, 32'h0000FFFF);
    chk("t6_ch1_hold", {16'd0, beat_cnt[31:16]}, 32'd5);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
